// File: rtl/memory_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch and
// load/store. Data has priority, bounded by a starvation cap that guarantees
// fetch progress; a cycle timeout turns a hung memory into a bus error.
module memory_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  // instruction fetch port
  input  logic                      inst_request,
  input  logic [ADDRESS_WIDTH-1:0]  inst_address,
  output logic                      inst_ready,
  output logic [DATA_WIDTH-1:0]     inst_data,
  // load/store port
  input  logic                      data_request,
  input  logic                      data_write,
  input  logic [DATA_WIDTH/8-1:0]   data_select,
  input  logic [ADDRESS_WIDTH-1:0]  data_address,
  input  logic [DATA_WIDTH-1:0]     data_write_data,
  output logic                      data_ready,
  output logic [DATA_WIDTH-1:0]     data_read_data,
  output logic                      bus_error,
  // memory side
  output logic                      mem_request,
  output logic                      mem_write,
  output logic [DATA_WIDTH/8-1:0]   mem_select,
  output logic [ADDRESS_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_read_data
);

  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TimerWidth  = $clog2(TIMEOUT);

  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(STARVE_LIMIT);
  // Timer holds the number of ack-less edges seen so far; the edge that
  // would make it TIMEOUT is the abort edge.
  localparam logic [TimerWidth-1:0]  TimerLast = TimerWidth'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StInst,
    StData,
    StDone
  } state_e;

  state_e                 state;
  logic [StarveWidth-1:0] starve_count;
  logic [TimerWidth-1:0]  timer;

  logic grant_data;
  logic grant_inst;

  // Grant decision in IDLE: data wins unless fetch has been starved too long.
  always_comb begin
    grant_data = data_request && (!inst_request || (starve_count < StarveMax));
    grant_inst = !grant_data && inst_request;
  end

  // Grant FSM with registered memory command and completion outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= StIdle;
      starve_count   <= '0;
      timer          <= '0;
      inst_ready     <= 1'b0;
      inst_data      <= '0;
      data_ready     <= 1'b0;
      data_read_data <= '0;
      bus_error      <= 1'b0;
      mem_request    <= 1'b0;
      mem_write      <= 1'b0;
      mem_select     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      // Completion strobes are single-cycle by default.
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      bus_error  <= 1'b0;

      unique case (state)
        StIdle: begin
          if (grant_data) begin
            state          <= StData;
            timer          <= '0;
            mem_request    <= 1'b1;
            mem_write      <= data_write;
            mem_select     <= data_select;
            mem_address    <= data_address;
            mem_write_data <= data_write_data;
            if (inst_request && (starve_count != StarveMax)) begin
              starve_count <= starve_count + 1'b1;
            end
          end else if (grant_inst) begin
            state          <= StInst;
            timer          <= '0;
            starve_count   <= '0;
            mem_request    <= 1'b1;
            mem_write      <= 1'b0;
            mem_select     <= '1;
            mem_address    <= inst_address;
            mem_write_data <= '0;
          end
        end

        StInst, StData: begin
          if (mem_ack) begin
            state       <= StDone;
            mem_request <= 1'b0;
            if (state == StInst) begin
              inst_data  <= mem_read_data;
              inst_ready <= 1'b1;
            end else begin
              // Stores return no data; keep the last load result visible.
              if (!mem_write) begin
                data_read_data <= mem_read_data;
              end
              data_ready <= 1'b1;
            end
          end else if (timer == TimerLast) begin
            state       <= StDone;
            mem_request <= 1'b0;
            bus_error   <= 1'b1;
            if (state == StInst) begin
              inst_data  <= '0;
              inst_ready <= 1'b1;
            end else begin
              if (!mem_write) begin
                data_read_data <= '0;
              end
              data_ready <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        StDone: begin
          // Requests are not sampled here; a held request is regranted from IDLE.
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single memory port of the SoC between the CPU instruction-fetch port and the load/store (data) port. It runs a four-state grant FSM. Data has priority, with a starvation cap that protects instruction fetch. A cycle timeout turns a hung memory into a bus error. The block sits between the CPU and the ROM/RAM bus inside the SoC top.

## Interface
- ADDRESS_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- STARVE_LIMIT, 4, max consecutive data grants while an instruction request waits (≥1)
- TIMEOUT, 16, cycles to wait for mem_ack before aborting (≥2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inst_request  in  1  fetch request, held until inst_ready
- inst_address  in  ADDRESS_WIDTH  fetch address
- inst_ready  out  1  one-cycle completion pulse
- inst_data  out  DATA_WIDTH  fetched word, valid with inst_ready
- data_request  in  1  load/store request, held until data_ready
- data_write  in  1  1 = store
- data_select  in  DATA_WIDTH/8  byte enables
- data_address  in  ADDRESS_WIDTH  load/store address
- data_write_data  in  DATA_WIDTH  store data
- data_ready  out  1  one-cycle completion pulse
- data_read_data  out  DATA_WIDTH  load data, valid with data_ready
- bus_error  out  1  pulses with a ready pulse when the transaction timed out
- mem_request  out  1  memory transaction active
- mem_write, mem_select, mem_address, mem_write_data  out  1, DATA_WIDTH/8, ADDRESS_WIDTH, DATA_WIDTH  memory command
- mem_ack  in  1  memory completion, sampled on the clock
- mem_read_data  in  DATA_WIDTH  memory read data, valid with mem_ack

## Operation
- All outputs are registered.
- Reset value of every output is 0.
- Reset value of FSM is IDLE; starve_count and timer are 0.
- States are IDLE, INST, DATA and DONE.
- IDLE, grant rule:
  - If data_request is high and (inst_request is low or starve_count < STARVE_LIMIT), go to DATA.
  - Otherwise, if inst_request is high, go to INST.
  - Otherwise, stay in IDLE.
- On the grant edge, the mem_* command is latched from the granted port and mem_request is set to 1. The command is held stable until the transaction ends.
- Inst grants issue mem_write = 0 and mem_select = all ones.
- starve_count:
  - Increments, saturating at STARVE_LIMIT, on a DATA grant while inst_request is high.
  - Clears on an INST grant.
  - Holds otherwise.
- INST/DATA, normal completion: the timer counts cycles in state. On mem_ack = 1:
  - Capture mem_read_data into inst_data or data_read_data.
  - Pulse the matching ready signal.
  - Drop mem_request.
  - Go to DONE.
- INST/DATA, timeout: if the timer reaches TIMEOUT without mem_ack:
  - Drop mem_request.
  - Return read data of 0.
  - Pulse ready and bus_error together.
  - Go to DONE.
- A request dropped mid-transaction does not abort it. The memory cycle completes and ready still pulses.
- Store completion leaves data_read_data unchanged.
- DONE lasts one cycle, during which ready (and possibly bus_error) are high. Requests are ignored in DONE, and the FSM then goes to IDLE.
- A requester must deassert in its ready cycle. A request still high at the end of DONE is treated as a new request.
- mem_ack while in IDLE or DONE is ignored.

## Timing
- Request sampled high at edge k (in IDLE) → mem_request high from edge k.
- mem_ack sampled at edge m → ready high from edge m for exactly one cycle. mem_request is low from edge m.
- A zero-wait memory (mem_ack high on the first cycle of mem_request) gives a request-to-ready latency of 2 cycles.
- Back-to-back throughput is one transaction per 3 cycles (grant, ack, DONE).
- Timeout: with mem_ack never asserted, ready and bus_error rise TIMEOUT cycles after mem_request rose.
- Simultaneous inst and data requests in IDLE: data wins until starve_count = STARVE_LIMIT, then inst wins once.
- Reset asserted mid-transaction clears all outputs immediately, with no clock needed. After release, the FSM is IDLE with no pending transaction.

## Test plan
- Reset: hold reset low 10 cycles with both requests high → all outputs 0. After release, the first grant is DATA.
- Single fetch: inst_address 0x00000004, memory returns 0x34011100 with 1 wait state → mem_address 0x00000004, mem_write 0. Then inst_ready pulses one cycle with inst_data 0x34011100.
- Store: data_write 1, select 0xF, address 0x10, data 0x00005520 → mem_* mirror the inputs. data_ready pulses on ack; data_read_data is unchanged.
- Starvation: both requests held continuously, zero-wait memory, STARVE_LIMIT = 4 → grant order D, D, D, D, I, D, D, D, D, I.
- Timeout: mem_ack tied 0 for a load → data_ready and bus_error pulse 16 cycles after mem_request rose, with data_read_data 0. A following fetch with a normal ack succeeds.
- Reset mid-transaction: assert reset 2 cycles into a DATA wait → mem_request falls asynchronously. After release, a fetch completes normally and no stale ready appears.
